// File: rtl/fp_add_writeback_stage.sv
// Writeback stage for the FP32 adder: converts the recoded sum to IEEE binary32,
// buffers it in a 2-entry in-order FIFO and keeps sticky exception flags.
module fp_add_writeback_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32:0]      in_data,
    input  logic [4:0]       in_exceptionFlags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       fflags,
    input  logic             fflags_clear,
    output logic [1:0]       count
);

    localparam int ENTRY_W = 32 + 5 + TAG_W;

    // Recoded exponent is biased by 129 relative to IEEE; anything below 130
    // that is not a zero lands in the IEEE subnormal range.
    function automatic logic [31:0] recode_to_ieee(input logic [32:0] rec);
        logic [8:0]  exp_v;
        logic [8:0]  shamt_v;
        logic [7:0]  norm_exp_v;
        logic [22:0] sub_frac_v;
        logic [31:0] res_v;
        exp_v      = rec[31:23];
        norm_exp_v = exp_v[7:0] - 8'd129;
        shamt_v    = 9'd130 - exp_v;
        sub_frac_v = 23'({1'b1, rec[22:0]} >> shamt_v);
        if (exp_v[8:7] == 2'b11) begin
            if (exp_v[6]) begin
                res_v = {rec[32], 8'hFF, rec[22:0]};
            end else begin
                res_v = {rec[32], 8'hFF, 23'h000000};
            end
        end else if (exp_v[8:6] == 3'b000) begin
            res_v = {rec[32], 31'h00000000};
        end else if (exp_v >= 9'd130) begin
            res_v = {rec[32], norm_exp_v, rec[22:0]};
        end else begin
            res_v = {rec[32], 8'h00, sub_frac_v};
        end
        return res_v;
    endfunction

    logic [ENTRY_W-1:0] slot0_r;
    logic [ENTRY_W-1:0] slot1_r;
    logic [1:0]         count_r;
    logic [4:0]         fflags_r;
    logic [ENTRY_W-1:0] new_entry_s;
    logic               accept_s;
    logic               pop_s;

    // Handshake decode and conversion of the incoming result.
    always_comb begin
        in_ready    = (count_r != 2'd2) & reset;
        out_valid   = (count_r != 2'd0);
        accept_s    = in_valid & in_ready;
        pop_s       = out_valid & out_ready;
        new_entry_s = {recode_to_ieee(in_data), in_exceptionFlags, in_tag};
    end

    // FIFO storage: slot0 is always the head, slot1 the second entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= 2'd0;
        end else begin
            case ({accept_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= new_entry_s;
                    end else begin
                        slot1_r <= new_entry_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    // With one entry the newcomer goes straight to the head.
                    if (count_r == 2'd1) begin
                        slot0_r <= new_entry_s;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= new_entry_s;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Sticky flag accumulator; a clear in the same cycle as an accept keeps only the new flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fflags_r <= 5'b00000;
        end else begin
            case ({accept_s, fflags_clear})
                2'b10:   fflags_r <= fflags_r | in_exceptionFlags;
                2'b01:   fflags_r <= 5'b00000;
                2'b11:   fflags_r <= in_exceptionFlags;
                default: fflags_r <= fflags_r;
            endcase
        end
    end

    assign out_data  = slot0_r[ENTRY_W-1 -: 32];
    assign out_flags = slot0_r[TAG_W +: 5];
    assign out_tag   = slot0_r[TAG_W-1:0];
    assign fflags    = fflags_r;
    assign count     = count_r;

endmodule

// File: tb/tb_fp_add_writeback_stage.sv
// Randomized self-checking bench for fp_add_writeback_stage with a queue-based reference model.
module tb_fp_add_writeback_stage;

    localparam int TAG_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [32:0]      in_data;
    logic [4:0]       in_exceptionFlags;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [4:0]       out_flags;
    logic [TAG_W-1:0] out_tag;
    logic [4:0]       fflags;
    logic             fflags_clear;
    logic [1:0]       count;

    fp_add_writeback_stage #(.TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_exceptionFlags(in_exceptionFlags), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_tag(out_tag),
        .fflags(fflags), .fflags_clear(fflags_clear), .count(count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [40:0] exp_q[$];
    logic [4:0]  ff_m     = 5'b00000;
    bit          rst_seen = 1'b0;
    bit          started  = 1'b0;

    logic [32:0] vin  [5];
    logic [31:0] vout [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference conversion from the category rules with plain integer arithmetic.
    function automatic logic [31:0] ref_conv(input logic [32:0] d);
        int          e;
        longint      m;
        int          sh;
        logic [22:0] f;
        logic [7:0]  ev;
        e = int'(d[31:23]);
        f = d[22:0];
        if (e >= 448) return {d[32], 8'hFF, f};
        if (e >= 384) return {d[32], 8'hFF, 23'h000000};
        if (e < 64)   return {d[32], 31'h00000000};
        if (e >= 130) begin
            ev = 8'(e - 129);
            return {d[32], ev, f};
        end
        sh = 130 - e;
        if (sh > 23) return {d[32], 31'h00000000};
        m = (longint'(64'h800000) + longint'(f)) / (longint'(1) << sh);
        return {d[32], 8'h00, 23'(m)};
    endfunction

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic step();
        bit acc;
        bit pp;
        @(posedge clock);
        started = 1'b1;
        if (!reset) begin
            exp_q.delete();
            ff_m     = 5'b00000;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            acc = in_valid && (exp_q.size() < 2);
            pp  = out_ready && (exp_q.size() > 0);
            if (pp) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({ref_conv(in_data), in_exceptionFlags, in_tag});
            if (acc && !fflags_clear)      ff_m = ff_m | in_exceptionFlags;
            else if (fflags_clear && !acc) ff_m = 5'b00000;
            else if (fflags_clear && acc)  ff_m = in_exceptionFlags;
        end
        #2;
    endtask

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clock) begin
        if (started) begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(reset && (exp_q.size() < 2)));
            chk("fflags", 32'(fflags), 32'(ff_m));
            if (exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0][40:9]);
                chk("out_flags", 32'(out_flags), 32'(exp_q[0][8:4]));
                chk("out_tag", 32'(out_tag), 32'(exp_q[0][3:0]));
            end else if (rst_seen) begin
                chk("rst_out_data", out_data, 32'h0);
                chk("rst_out_flags", 32'(out_flags), 32'h0);
                chk("rst_out_tag", 32'(out_tag), 32'h0);
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = 33'h0; in_exceptionFlags = 5'b00000;
        in_tag = 4'h0; out_ready = 1'b0; fflags_clear = 1'b0;
        vin[0] = 33'h0_8000_0000; vout[0] = 32'h3F80_0000;
        vin[1] = 33'h0_C000_0000; vout[1] = 32'h7F80_0000;
        vin[2] = 33'h0_E040_0000; vout[2] = 32'h7FC0_0000;
        vin[3] = 33'h1_0000_0000; vout[3] = 32'h8000_0000;
        vin[4] = 33'h0_4080_0000; vout[4] = 32'h0040_0000;

        for (int i = 0; i < 5; i++) chk("model_pin", ref_conv(vin[i]), vout[i]);

        repeat (3) step();
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        reset = 1'b1;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'h1);

        // Directed conversions, each pushed and then drained.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = vin[i]; in_tag = 4'(i);
            step();
            in_valid = 1'b0;
            chk("conv_data", out_data, vout[i]);
            chk("conv_valid", 32'(out_valid), 32'h1);
            step();
        end

        // Back-pressure: two accepted, third held, then in-order drain.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 33'h0_8000_0000; in_tag = 4'h1;
        step();
        in_tag = 4'h2;
        step();
        chk("bp_count", 32'(count), 32'h2);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        in_tag = 4'h3;
        step();
        chk("bp_hold_count", 32'(count), 32'h2);
        chk("bp_head_tag1", 32'(out_tag), 32'h1);
        out_ready = 1'b1;
        step();
        chk("bp_head_tag2", 32'(out_tag), 32'h2);
        step();
        chk("bp_head_tag3", 32'(out_tag), 32'h3);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 32'(count), 32'h0);

        // Sticky flags and clear-with-accept.
        fflags_clear = 1'b1;
        step();
        fflags_clear = 1'b0;
        chk("ff_cleared", 32'(fflags), 32'h0);
        in_valid = 1'b1; in_exceptionFlags = 5'b00001;
        step();
        in_exceptionFlags = 5'b10000;
        step();
        chk("ff_accum", 32'(fflags), 32'h11);
        in_exceptionFlags = 5'b00100; fflags_clear = 1'b1;
        step();
        in_valid = 1'b0; fflags_clear = 1'b0;
        chk("ff_clear_accept", 32'(fflags), 32'h04);
        step();

        // Reset with a full buffer.
        out_ready = 1'b0; in_valid = 1'b1; in_exceptionFlags = 5'b01000; in_tag = 4'h7;
        step();
        in_tag = 4'h8;
        step();
        in_valid = 1'b0;
        chk("full_before_reset", 32'(count), 32'h2);
        reset = 1'b0;
        step();
        chk("mid_reset_count", 32'(count), 32'h0);
        chk("mid_reset_valid", 32'(out_valid), 32'h0);
        chk("mid_reset_fflags", 32'(fflags), 32'h0);
        reset = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = {1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 23'($urandom)};
            if ($urandom_range(0, 3) == 0) in_data[31:23] = 9'($urandom_range(120, 135));
            in_exceptionFlags = 5'($urandom);
            in_tag       = 4'($urandom);
            out_ready    = ($urandom_range(0, 99) < 65);
            fflags_clear = ($urandom_range(0, 99) < 8);
            reset        = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
